// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter and access sequencer sharing one data memory
// between the MEM stage (port 0) and a debug/loader port (port 1).
module data_memory_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic        last_q, last_d;
  logic        gid_q, gid_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_bad;

  // On a tie the port that was not served last wins
  always_comb begin
    sel = 1'b0;
    if (req0 && req1) sel = ~last_q;
    else              sel = req1;
    sel_we    = sel ? we1    : we0;
    sel_addr  = sel ? addr1  : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
    sel_bad   = (sel_addr[1:0] != 2'b00);
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    last_d   = last_q;
    gid_d    = gid_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          last_d  = sel;
          gid_d   = sel;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          err_d   = sel_bad;
          wait_d  = sel_bad ? 4'd0 : WaitInit;
          state_d = sel_bad ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          state_d = RESP;
          // Load data lands in the port register so it is valid with ack
          if (!we_q) begin
            if (gid_q) rdata1_d = mem_rdata;
            else       rdata0_d = mem_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wait_q   <= 4'd0;
      last_q   <= 1'b1;
      gid_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      last_q   <= last_d;
      gid_q    <= gid_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  logic in_acc;
  logic in_resp;

  assign in_acc    = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);
  assign ack0      = in_resp && !gid_q;
  assign ack1      = in_resp && gid_q;
  assign err0      = ack0 && err_q;
  assign err1      = ack1 && err_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_addr  = in_acc ? addr_q : '0;
  assign mem_wdata = in_acc ? wdata_q : '0;
  assign mem_read  = in_acc && !we_q;
  assign mem_write = in_acc && we_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = gid_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: stimulus pushes expected
// acks, a negedge monitor pops and compares them.
module tb_data_memory_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, busy, grant_id;

  data_memory_arbiter #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
  );

  logic        s_req0 = 0, s_zero = 0;
  logic [31:0] s_addr0 = 0, s_zw = 0;
  logic        s_ack0, s_ack1, s_err0, s_err1;
  logic [31:0] s_rdata0, s_rdata1;
  logic [31:0] s_maddr, s_mwdata, s_mrdata;
  logic        s_mread, s_mwrite, s_busy, s_gid;

  data_memory_arbiter #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .req0(s_req0), .req1(s_zero), .we0(s_zero), .we1(s_zero),
    .addr0(s_addr0), .addr1(s_zw), .wdata0(s_zw), .wdata1(s_zw),
    .ack0(s_ack0), .ack1(s_ack1), .err0(s_err0), .err1(s_err1),
    .rdata0(s_rdata0), .rdata1(s_rdata1),
    .mem_addr(s_maddr), .mem_wdata(s_mwdata),
    .mem_read(s_mread), .mem_write(s_mwrite),
    .mem_rdata(s_mrdata), .busy(s_busy), .grant_id(s_gid)
  );

  // Memory models
  logic [31:0] mem [1024];
  logic [31:0] mem3 [1024];
  logic        hi_ok, hi_ok3;

  assign hi_ok  = (mem_addr[31:12] == 20'd0) && (mem_addr[1:0] == 2'd0);
  assign hi_ok3 = (s_maddr[31:12] == 20'd0) && (s_maddr[1:0] == 2'd0);
  assign mem_rdata = hi_ok  ? mem[mem_addr[11:2]] : 32'd0;
  assign s_mrdata  = hi_ok3 ? mem3[s_maddr[11:2]] : 32'd0;

  always @(posedge clk) begin
    if (mem_write && hi_ok) mem[mem_addr[11:2]] <= mem_wdata;
    if (s_mwrite && hi_ok3) mem3[s_maddr[11:2]] <= s_mwdata;
  end

  int cyc = 0;
  int mw_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_write) mw_cnt <= mw_cnt + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          err;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic expect_ack(input bit p, input bit err,
                            input logic [31:0] rd, input int c);
    exp_t e;
    e.err = err;
    e.rd  = rd;
    e.cyc = c;
    if (p) q1.push_back(e);
    else   q0.push_back(e);
  endtask

  task automatic check_ack(input bit p);
    exp_t e;
    logic [31:0] rd;
    logic er;
    rd = p ? rdata1 : rdata0;
    er = p ? err1 : err0;
    if ((p && q1.size() == 0) || (!p && q0.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL unexpected_ack port=%0d got=1 want=0", p);
    end else begin
      e = p ? q1.pop_front() : q0.pop_front();
      chk(p ? "ack1_cycle" : "ack0_cycle", 32'(cyc), 32'(e.cyc));
      chk(p ? "err1" : "err0", {31'd0, er}, {31'd0, e.err});
      chk(p ? "rdata1" : "rdata0", rd, e.rd);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ack0) check_ack(1'b0);
      if (ack1) check_ack(1'b1);
    end
  end

  int left0 = 0;
  int left1 = 0;

  task automatic issue(input bit p, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input int n);
    if (!p) begin
      we0 = we; addr0 = a; wdata0 = wd; req0 = 1'b1; left0 = n;
    end else begin
      we1 = we; addr1 = a; wdata1 = wd; req1 = 1'b1; left1 = n;
    end
  endtask

  task automatic run();
    int guard;
    bit a0, a1;
    guard = 0;
    while ((req0 || req1) && guard < 60) begin
      @(negedge clk);
      a0 = ack0;
      a1 = ack1;
      @(posedge clk); #1;
      if (a0 && left0 > 0) begin
        left0--;
        if (left0 == 0) req0 = 1'b0;
      end
      if (a1 && left1 > 0) begin
        left1--;
        if (left1 == 0) req1 = 1'b0;
      end
      guard++;
    end
    total++;
    if (guard >= 60) begin
      bad++;
      $display("FAIL run_timeout got=%0d want=<60", guard);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, mw0, rd_n, busy_n, ack_n, ack_c;
    logic [31:0] ack_d;
    bit drop;
    for (int i = 0; i < 1024; i++) begin
      mem[i]  = 32'd0;
      mem3[i] = 32'd0;
    end
    mem[16] = 32'h1111_1111;
    mem[17] = 32'h2222_2222;
    mem3[2] = 32'hA5A5_A5A5;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_acks", {28'd0, ack0, ack1, err0, err1}, 32'd0);
    chk("reset_rdata0", rdata0, 32'd0);
    chk("reset_rdata1", rdata1, 32'd0);
    chk("reset_mem_ctl", {29'd0, mem_read, mem_write, busy}, 32'd0);
    chk("reset_mem_addr", mem_addr | mem_wdata, 32'd0);
    chk("reset_grant_id", {31'd0, grant_id}, 32'd0);
    @(posedge clk); #1;

    // Store then load of the same word
    mw0 = mw_cnt;
    k = cyc;
    issue(0, 1, 32'h20, 32'hDEAD_BEEF, 1);
    expect_ack(0, 0, 32'd0, k + 2);
    run();
    chk("store_mw_cycles", 32'(mw_cnt - mw0), 32'd1);
    chk("store_mem_0x20", mem[8], 32'hDEAD_BEEF);
    k = cyc;
    issue(1, 0, 32'h20, 32'h0, 1);
    expect_ack(1, 0, 32'hDEAD_BEEF, k + 2);
    run();

    // Simultaneous loads: port 0 wins the first tie
    k = cyc;
    issue(0, 0, 32'h40, 32'h0, 1);
    issue(1, 0, 32'h44, 32'h0, 1);
    expect_ack(0, 0, 32'h1111_1111, k + 2);
    expect_ack(1, 0, 32'h2222_2222, k + 5);
    run();
    chk("grant_after_pair", {31'd0, grant_id}, 32'd1);
    chk("idle_after_pair", {31'd0, busy}, 32'd0);

    // Misaligned store: no strobe, error ack one cycle early
    mw0 = mw_cnt;
    k = cyc;
    issue(0, 1, 32'h22, 32'h1234_5678, 1);
    expect_ack(0, 1, 32'h1111_1111, k + 1);
    run();
    chk("misaligned_mw", 32'(mw_cnt - mw0), 32'd0);
    chk("grant_after_mis", {31'd0, grant_id}, 32'd0);
    k = cyc;
    issue(0, 0, 32'h20, 32'h0, 1);
    expect_ack(0, 0, 32'hDEAD_BEEF, k + 2);
    run();

    // Port 0 served last, so port 1 wins this tie
    k = cyc;
    issue(0, 0, 32'h44, 32'h0, 1);
    issue(1, 0, 32'h40, 32'h0, 1);
    expect_ack(1, 0, 32'h1111_1111, k + 2);
    expect_ack(0, 0, 32'h2222_2222, k + 5);
    run();

    // Held request produces a second access
    k = cyc;
    issue(0, 0, 32'h40, 32'h0, 2);
    expect_ack(0, 0, 32'h1111_1111, k + 2);
    expect_ack(0, 0, 32'h1111_1111, k + 5);
    run();

    k = cyc;
    issue(1, 0, 32'h41, 32'h0, 1);
    expect_ack(1, 1, 32'h1111_1111, k + 1);
    run();

    // Three-cycle memory on the second instance
    rd_n = 0; busy_n = 0; ack_n = 0; ack_c = 0; ack_d = 0;
    k = cyc;
    s_addr0 = 32'h8;
    s_req0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drop = 1'b0;
      if (s_mread) rd_n++;
      if (s_busy) busy_n++;
      if (s_ack0) begin
        ack_n++;
        ack_c = cyc;
        ack_d = s_rdata0;
        drop = 1'b1;
      end
      @(posedge clk); #1;
      if (drop) s_req0 = 1'b0;
    end
    chk("w3_read_cycles", 32'(rd_n), 32'd3);
    chk("w3_busy_cycles", 32'(busy_n), 32'd4);
    chk("w3_ack_count", 32'(ack_n), 32'd1);
    chk("w3_ack_cycle", 32'(ack_c), 32'(k + 4));
    chk("w3_rdata", ack_d, 32'hA5A5_A5A5);

    // Reset in the middle of a store
    issue(0, 1, 32'h10, 32'hCAFE_F00D, 1);
    @(posedge clk); #1;
    chk("pre_rst_mem_write", {31'd0, mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_drops_write", {31'd0, mem_write}, 32'd0);
    chk("rst_busy_mid", {31'd0, busy}, 32'd0);
    chk("rst_mem_bus", mem_addr | mem_wdata, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_grant", {31'd0, grant_id}, 32'd0);
    req0 = 1'b0;
    we0 = 1'b0;
    left0 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("no_write_0x10", mem[4], 32'd0);
    chk("pending_q0", 32'(q0.size()), 32'd0);
    chk("pending_q1", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter and access sequencer for the single-ported, byte-addressed `DataMemory`. It shares the memory between requester 0 (the pipeline MEM stage, load/store) and requester 1 (a debug/loader port). It grants one request at a time, round-robin on conflict, and drives `MemoryRead`/`MemoryWrite`/address/write-data for a fixed number of cycles. It returns read data with a one-cycle `ack` pulse and rejects misaligned word accesses without touching memory.

## Interface
- `WAIT_CYCLES`, default 1: number of cycles memory controls are held per access; legal range 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0`, `req1` in 1: access request, held high until the matching `ack`.
- `we0`, `we1` in 1: 1 = store word, 0 = load word; sampled with `req`.
- `addr0`, `addr1` in 32: byte address; word accesses must have `addr[1:0]==0`.
- `wdata0`, `wdata1` in 32: store data, held stable until `ack`.
- `ack0`, `ack1` out 1: one-cycle completion pulse.
- `err0`, `err1` out 1: high with `ack` when the access was rejected as misaligned.
- `rdata0`, `rdata1` out 32: load data, valid in the `ack` cycle and held until the next ack to that port.
- `mem_addr` out 32: to `DataMemory` address (ALUResult) input.
- `mem_wdata` out 32: to `DataMemory` write-data input.
- `mem_read`, `mem_write` out 1: to `MemoryRead` and `MemoryWrite`.
- `mem_rdata` in 32: from `readDataMemory`.
- `busy` out 1: high in any state other than IDLE.
- `grant_id` out 1: index of the requester currently or last served.

## Operation
- States: IDLE, ACCESS, RESP. Registers: `state`, `wait_cnt` (4 bits), `last_grant`, and latched `cur_we`, `cur_addr`, `cur_wdata`.
- IDLE, no request: stay in IDLE. All memory controls are 0.
- IDLE, one request: grant that port.
- IDLE, both requests: grant the port not equal to `last_grant`.
- On grant:
  - Latch the granted port's `we`, `addr` and `wdata`, and set `grant_id` and `last_grant`.
  - If `addr[1:0]!=0`, go directly to RESP with the error flag set. No memory strobe is issued.
  - Otherwise go to ACCESS with `wait_cnt = WAIT_CYCLES-1`.
- ACCESS:
  - `mem_addr` = `cur_addr`; `mem_wdata` = `cur_wdata`.
  - `mem_read` = `!cur_we`; `mem_write` = `cur_we`. Exactly one of the two is high.
  - While `wait_cnt != 0`, decrement it.
  - At `wait_cnt == 0`: capture `mem_rdata` for loads, then go to RESP.
- RESP: pulse `ack` (and `err` if flagged) on the granted port; update that port's `rdata`. The next state is always IDLE.
- A requester still holding `req` in the cycle after `ack` is treated as a new request. Requesters must drop `req` on the edge that ends the `ack` cycle.
- Store data is never written through to `rdata`. A store `ack` leaves `rdata` unchanged.
- Changes to a requester's inputs while it is not granted are ignored. Changes while granted have no effect, because the inputs are latched.

## Timing
- Reset values:
  - `state` = IDLE, `wait_cnt` = 0, `last_grant` = 1, so port 0 wins the first tie.
  - `grant_id` = 0; all `ack`/`err` = 0; `rdata0`/`rdata1` = 0.
  - `mem_read`/`mem_write` = 0; `mem_addr`/`mem_wdata` = 0; `busy` = 0.
- Latency with `req` sampled at edge k:
  - ACCESS runs from edge k+1 to edge k+1+WAIT_CYCLES.
  - `ack` is high for the single cycle after edge k+1+WAIT_CYCLES.
  - State returns to IDLE at edge k+2+WAIT_CYCLES.
- Throughput: one access per WAIT_CYCLES+2 cycles per port; two back-to-back accesses (a single-port burst or both ports contending) take 2·(WAIT_CYCLES+2) cycles.
- Misaligned access: `ack`+`err` occur the cycle after edge k+1. Total 2 cycles; `mem_read`/`mem_write` never assert.
- `mem_*` outputs are registered/state-decoded with no combinational path from `req*`. They are zero outside ACCESS.
- Reset mid-access:
  - Everything returns to reset values immediately, asynchronously.
  - `mem_write` drops before the next edge, so no write is committed at that edge.
  - No `ack` is issued for the abandoned request; the requester must re-request after reset.
- `grant_id` changes only on grant; its value persists through RESP and IDLE.

## Test plan
- Reset: assert `rst` mid-simulation with `req0` high in ACCESS (`we0`=1) → `mem_write`=0 immediately, all outputs at reset values, and no memory change at address 0x10 on following edges.
- Single store/load, WAIT_CYCLES=1: port 0 stores 0xDEADBEEF at 0x20; port 1 then loads from 0x20.
  - Required: each `ack` arrives 2 cycles after `req` is sampled.
  - Required: `mem_write` is high for exactly 1 cycle.
  - Required: `rdata1` = 0xDEADBEEF.
- Contention: `req0` and `req1` rise in the same cycle after reset, both loads.
  - Required: port 0 is served first, then port 1, with no idle gap beyond IDLE.
  - Required: a third simultaneous pair is served port 1 first (round-robin).
- Misaligned: `req0` store to 0x22 → `ack0` and `err0` high in the same cycle, 1 cycle after sampling; `mem_write` never high; a later load of 0x20 returns the prior value.
- WAIT_CYCLES=3: a load is held on `mem_read` for exactly 3 cycles, `ack` arrives 4 cycles after sampling, and `busy` is high for 4 cycles.
- Held request: port 0 keeps `req0` high past `ack` → a second access starts, and `ack0` pulses again 1+WAIT_CYCLES cycles after IDLE.
